// File: rtl/fpga_led_pkg.sv
// -----------------------------------------------------------------------------
// fpga_led_pkg
// Shared types for the board-status LED driver: the per-channel mode encoding
// and its field width, imported by the top and the stretcher sub-module.
// -----------------------------------------------------------------------------
package fpga_led_pkg;

  localparam int LedModeW = 2;

  typedef enum logic [LedModeW-1:0] {
    LED_OFF     = 2'd0,
    LED_ON      = 2'd1,
    LED_BLINK   = 2'd2,
    LED_STRETCH = 2'd3
  } led_mode_e;

endpackage : fpga_led_pkg

// File: rtl/fpga_led_stretcher.sv
// -----------------------------------------------------------------------------
// fpga_led_stretcher
// Widens single-cycle event strobes into pulses long enough to see on an LED.
// An event (re)loads the counter with STRETCH_CYCLES; otherwise it counts down
// to zero and holds there. While disabled the counter is held at zero, so a
// channel entering stretch mode always starts dark.
//
// Ports:
//   clk_i     system clock
//   rst_i     asynchronous active-high reset
//   en_i      channel is in stretch mode
//   event_i   single-cycle event strobe
//   active_o  next-state "lit" flag (next counter value != 0), combinational;
//             the top registers it into the LED drive
// -----------------------------------------------------------------------------
module fpga_led_stretcher #(
  parameter int unsigned STRETCH_CYCLES = 2**20
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  input  logic event_i,
  output logic active_o
);

  localparam int unsigned STRETCH_W = $clog2(STRETCH_CYCLES + 1);
  localparam logic [STRETCH_W-1:0] LoadVal = STRETCH_W'(STRETCH_CYCLES);

  logic [STRETCH_W-1:0] cnt_q, cnt_d;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i) begin
      cnt_d = '0;
    end else if (event_i) begin
      // Reload wins over decrement, including on the last lit cycle.
      cnt_d = LoadVal;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - STRETCH_W'(1);
    end
  end

  assign active_o = (cnt_d != '0);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the edge regardless of block order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : fpga_led_stretcher

// File: rtl/fpga_status_led_ctrl.sv
// -----------------------------------------------------------------------------
// fpga_status_led_ctrl
// Board-status LED driver. A shared free-running prescaler provides blink and
// heartbeat timing; each channel selects OFF / ON / BLINK / STRETCH; a sticky
// latch records the first program-exit strobe and shows pass (steady on) or
// fail (fast blink).
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   mode_i        per-channel mode, channel i = mode_i[2i+1:2i]
//   phase_i       per-channel blink phase invert
//   event_i       per-channel single-cycle event strobe (stretch mode)
//   exit_valid_i  program-finished strobe/level
//   exit_value_i  bit 0 of the program exit value
//   led_o         registered LED drive, 1 = lit
//   heartbeat_o   prescaler MSB
//   exit_led_o    sticky exit indication
// -----------------------------------------------------------------------------
module fpga_status_led_ctrl
  import fpga_led_pkg::*;
#(
  parameter int unsigned NUM_LEDS       = 4,
  parameter int unsigned CNT_WIDTH      = 27,
  parameter int unsigned STRETCH_CYCLES = 2**20
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic [LedModeW*NUM_LEDS-1:0] mode_i,
  input  logic [NUM_LEDS-1:0]          phase_i,
  input  logic [NUM_LEDS-1:0]          event_i,
  input  logic                         exit_valid_i,
  input  logic                         exit_value_i,
  output logic [NUM_LEDS-1:0]          led_o,
  output logic                         heartbeat_o,
  output logic                         exit_led_o
);

  // Fast-blink tap for a failed exit: a quarter of the heartbeat period.
  localparam int unsigned ExitBit = (CNT_WIDTH >= 3) ? CNT_WIDTH - 3 : 0;

  logic [CNT_WIDTH-1:0] cnt_q;
  logic [NUM_LEDS-1:0]  led_q, led_d;
  logic [NUM_LEDS-1:0]  stretch_active;
  logic                 exit_latched_q, exit_value_q;
  led_mode_e            mode_ch [NUM_LEDS];

  for (genvar i = 0; i < NUM_LEDS; i++) begin : g_chan
    assign mode_ch[i] = led_mode_e'(mode_i[LedModeW*i +: LedModeW]);

    fpga_led_stretcher #(
      .STRETCH_CYCLES (STRETCH_CYCLES)
    ) u_stretcher (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (mode_ch[i] == LED_STRETCH),
      .event_i  (event_i[i]),
      .active_o (stretch_active[i])
    );
  end

  // Blink uses the pre-increment counter, so the channel output lags the
  // prescaler MSB by exactly the one register stage every mode shares.
  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_LEDS; i++) begin
      unique case (mode_ch[i])
        LED_OFF:     led_d[i] = 1'b0;
        LED_ON:      led_d[i] = 1'b1;
        LED_BLINK:   led_d[i] = cnt_q[CNT_WIDTH-1] ^ phase_i[i];
        LED_STRETCH: led_d[i] = stretch_active[i];
        default:     led_d[i] = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q          <= '0;
      led_q          <= '0;
      exit_latched_q <= 1'b0;
      exit_value_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
      led_q <= led_d;
      // Only the first exit strobe after reset is captured.
      if (!exit_latched_q && exit_valid_i) begin
        exit_latched_q <= 1'b1;
        exit_value_q   <= exit_value_i;
      end
    end
  end

  assign led_o       = led_q;
  assign heartbeat_o = cnt_q[CNT_WIDTH-1];

  // Decoded straight from registers: pass = steady on, fail = fast blink.
  always_comb begin
    exit_led_o = 1'b0;
    if (exit_latched_q) begin
      exit_led_o = exit_value_q ? ~cnt_q[ExitBit] : 1'b1;
    end
  end

endmodule : fpga_status_led_ctrl

// File: tb/tb_fpga_status_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fpga_status_led_ctrl
// Self-checking bench for fpga_status_led_ctrl (NUM_LEDS=4, CNT_WIDTH=4,
// STRETCH_CYCLES=5). The reference model counts clock edges since reset and
// remembers, per channel, the edge of the most recent stretch event; the
// expected outputs follow directly from those numbers.
// -----------------------------------------------------------------------------
module tb_fpga_status_led_ctrl;

  localparam int NL     = 4;
  localparam int CW     = 4;
  localparam int SC     = 5;
  localparam int PERIOD = 1 << CW;
  localparam int NEVER  = -100000;

  logic          clk;
  logic          rst;
  logic [2*NL-1:0] mode;
  logic [NL-1:0] phase;
  logic [NL-1:0] ev;
  logic          exit_valid;
  logic          exit_value;
  logic [NL-1:0] led_o;
  logic          heartbeat_o;
  logic          exit_led_o;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int          n_cyc;
  int          last_evt [NL];
  bit          ex_lat, ex_val;
  logic [NL-1:0] exp_led;
  logic        exp_hb, exp_exit;

  fpga_status_led_ctrl #(
    .NUM_LEDS       (NL),
    .CNT_WIDTH      (CW),
    .STRETCH_CYCLES (SC)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .mode_i       (mode),
    .phase_i      (phase),
    .event_i      (ev),
    .exit_valid_i (exit_valid),
    .exit_value_i (exit_value),
    .led_o        (led_o),
    .heartbeat_o  (heartbeat_o),
    .exit_led_o   (exit_led_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    n_cyc    = 0;
    for (int i = 0; i < NL; i++) last_evt[i] = NEVER;
    ex_lat   = 1'b0;
    ex_val   = 1'b0;
    exp_led  = '0;
    exp_hb   = 1'b0;
    exp_exit = 1'b0;
  endtask

  // Advance one clock edge and update the model with the inputs seen there.
  task automatic tick();
    logic [2*NL-1:0] m;
    logic [NL-1:0]   p, e;
    logic            v, x;
    int              pre, md, now;
    m = mode; p = phase; e = ev; v = exit_valid; x = exit_value;
    @(posedge clk);
    #1;
    pre = n_cyc % PERIOD;
    n_cyc++;
    now = n_cyc % PERIOD;
    for (int i = 0; i < NL; i++) begin
      md = int'(m[2*i +: 2]);
      if (md != 3)  last_evt[i] = NEVER;
      else if (e[i]) last_evt[i] = n_cyc;
      case (md)
        0: exp_led[i] = 1'b0;
        1: exp_led[i] = 1'b1;
        2: exp_led[i] = ((pre >= PERIOD / 2) ? 1'b1 : 1'b0) ^ p[i];
        default: exp_led[i] = (n_cyc - last_evt[i]) < SC;
      endcase
    end
    if (!ex_lat && v) begin
      ex_lat = 1'b1;
      ex_val = x;
    end
    exp_hb = (now >= PERIOD / 2);
    if (!ex_lat)      exp_exit = 1'b0;
    else if (!ex_val) exp_exit = 1'b1;
    else              exp_exit = ~(((now >> (CW - 3)) & 1) != 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle_inputs();
    mode = '0; phase = '0; ev = '0; exit_valid = 1'b0; exit_value = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #12;
    n_checks++;
    if (led_o !== '0) begin
      n_fail++; $display("FAIL reset_led got=%b want=%b", led_o, 4'b0);
    end
    n_checks++;
    if (heartbeat_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_hb got=%b want=0", heartbeat_o);
    end
    n_checks++;
    if (exit_led_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_exit got=%b want=0", exit_led_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  // ch0 ON, ch1 OFF, ch2 BLINK phase0, ch3 BLINK phase1
  task automatic test_static_blink();
    logic want2;
    do_reset();
    mode  = 8'b10_10_00_01;
    phase = 4'b1000;
    for (int j = 0; j < 2 * PERIOD; j++) begin
      tick();
      want2 = ((j % PERIOD) >= PERIOD / 2);
      n_checks++;
      if (led_o !== {~want2, want2, 1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL static_blink j=%0d got=%b want=%b", j, led_o, {~want2, want2, 1'b0, 1'b1});
      end
      n_checks++;
      if (heartbeat_o !== (((j + 1) % PERIOD) >= PERIOD / 2)) begin
        n_fail++;
        $display("FAIL heartbeat j=%0d got=%b", j, heartbeat_o);
      end
      n_checks++;
      if (led_o !== exp_led) begin
        n_fail++; $display("FAIL static_model j=%0d got=%b want=%b", j, led_o, exp_led);
      end
    end
  endtask

  // Single event (ev_b < 0) or two events at offsets 0 and ev_b; ch0 lit
  // through last_lit edges after the first event.
  task automatic run_stretch(input string name, input int ev_b, input int last_lit);
    logic want;
    mode = 8'b00_00_00_00;
    ev   = '0;
    tick();
    mode = 8'b00_00_00_11;
    tick();
    tick();
    for (int j = 0; j < last_lit + 4; j++) begin
      ev[0] = (j == 0) || (j == ev_b);
      tick();
      want = (j <= last_lit);
      n_checks++;
      if (led_o[0] !== want) begin
        n_fail++; $display("FAIL %s j=%0d got=%b want=%b", name, j, led_o[0], want);
      end
      n_checks++;
      if (led_o[0] !== exp_led[0]) begin
        n_fail++; $display("FAIL %s_model j=%0d got=%b want=%b", name, j, led_o[0], exp_led[0]);
      end
    end
    ev = '0;
  endtask

  task automatic test_stretch();
    do_reset();
    run_stretch("stretch_single", -1, SC - 1);
    run_stretch("stretch_retrig", 3, 3 + SC - 1);
    run_stretch("stretch_lastcnt", SC - 1, 2 * SC - 2);
  endtask

  task automatic test_mode_switch();
    mode = 8'b00_00_00_11;
    ev   = '0;
    tick();
    for (int j = 0; j < 12; j++) begin
      ev[0] = (j == 0);
      if (j == 2)      mode = 8'b00_00_00_00;
      else if (j == 4) mode = 8'b00_00_00_11;
      tick();
      n_checks++;
      if (led_o[0] !== (j < 2)) begin
        n_fail++; $display("FAIL mode_switch j=%0d got=%b want=%b", j, led_o[0], (j < 2));
      end
    end
    ev = '0;
  endtask

  task automatic test_exit_pass();
    idle_inputs();
    do_reset();
    tick(); tick();
    n_checks++;
    if (exit_led_o !== 1'b0) begin
      n_fail++; $display("FAIL exit_idle got=%b want=0", exit_led_o);
    end
    exit_valid = 1'b1; exit_value = 1'b0;
    tick();
    exit_valid = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (j == 9) begin exit_valid = 1'b1; exit_value = 1'b1; end
      else exit_valid = 1'b0;
      n_checks++;
      if (exit_led_o !== 1'b1) begin
        n_fail++; $display("FAIL exit_pass j=%0d got=%b want=1", j, exit_led_o);
      end
      tick();
    end
    exit_valid = 1'b0;
  endtask

  task automatic test_exit_fail();
    idle_inputs();
    do_reset();
    exit_valid = 1'b1; exit_value = 1'b1;
    tick();
    exit_valid = 1'b0;
    for (int j = 0; j < 24; j++) begin
      if (j == 7) begin exit_valid = 1'b1; exit_value = 1'b0; end
      else exit_valid = 1'b0;
      n_checks++;
      if (exit_led_o !== ~((((n_cyc % PERIOD) >> 1) & 1) != 0)) begin
        n_fail++; $display("FAIL exit_fail n=%0d got=%b", n_cyc, exit_led_o);
      end
      n_checks++;
      if (exit_led_o !== exp_exit) begin
        n_fail++; $display("FAIL exit_fail_model n=%0d got=%b want=%b", n_cyc, exit_led_o, exp_exit);
      end
      tick();
    end
    exit_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    idle_inputs();
    do_reset();
    mode = 8'b00_00_01_11;
    exit_valid = 1'b1;
    for (int j = 0; j < 10; j++) begin
      ev[0] = (j == 8);
      tick();
      exit_valid = 1'b0;
    end
    ev = '0;
    n_checks++;
    if (led_o !== 4'b0011 || heartbeat_o !== 1'b1 || exit_led_o !== 1'b1) begin
      n_fail++;
      $display("FAIL async_pre got led=%b hb=%b exit=%b want led=0011 hb=1 exit=1", led_o, heartbeat_o, exit_led_o);
    end
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (led_o !== '0 || heartbeat_o !== 1'b0 || exit_led_o !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset got led=%b hb=%b exit=%b want all 0", led_o, heartbeat_o, exit_led_o);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    mode = 8'b00_00_00_10;
    for (int j = 0; j < PERIOD; j++) begin
      tick();
      n_checks++;
      if (heartbeat_o !== (((j + 1) % PERIOD) >= PERIOD / 2) || led_o !== exp_led) begin
        n_fail++;
        $display("FAIL async_restart j=%0d hb=%b led=%b want led=%b", j, heartbeat_o, led_o, exp_led);
      end
    end
  endtask

  task automatic test_random();
    idle_inputs();
    do_reset();
    for (int j = 0; j < 400; j++) begin
      if ($urandom_range(0, 15) == 0) mode  = 8'($urandom);
      if ($urandom_range(0, 31) == 0) phase = 4'($urandom);
      for (int i = 0; i < NL; i++) ev[i] = ($urandom_range(0, 5) == 0);
      exit_valid = ($urandom_range(0, 60) == 0);
      exit_value = 1'($urandom);
      tick();
      n_checks++;
      if (led_o !== exp_led) begin
        n_fail++; $display("FAIL rand_led j=%0d got=%b want=%b", j, led_o, exp_led);
      end
      n_checks++;
      if (heartbeat_o !== exp_hb) begin
        n_fail++; $display("FAIL rand_hb j=%0d got=%b want=%b", j, heartbeat_o, exp_hb);
      end
      n_checks++;
      if (exit_led_o !== exp_exit) begin
        n_fail++; $display("FAIL rand_exit j=%0d got=%b want=%b", j, exit_led_o, exp_exit);
      end
    end
    idle_inputs();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_static_blink();
    test_stretch();
    test_mode_switch();
    test_exit_pass();
    test_exit_fail();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_fpga_status_led_ctrl
